// File: rtl/jtkiwi_scan_if.sv
`default_nettype none
// ============================================================================
// Module   : jtkiwi_scan_if
// Purpose  : Scanner-to-tile-drawer bus. The scanner issues a one-clock draw
//            strobe together with the tile descriptor; the drawer answers
//            with busy while it consumes the descriptor.
// Signals  : draw  - one-clock tile-draw request (scanner -> drawer)
//            code  - tile code                     (scanner -> drawer)
//            attr  - tile attribute                (scanner -> drawer)
//            xpos  - tile start pixel in the line  (scanner -> drawer)
//            ysub  - row inside the tile           (scanner -> drawer)
//            busy  - drawer busy                   (drawer  -> scanner)
// Revision : 1.0 - initial release
// ============================================================================
interface jtkiwi_scan_if;
  logic        draw;
  logic [15:0] code;
  logic [15:0] attr;
  logic [8:0]  xpos;
  logic [3:0]  ysub;
  logic        busy;

  modport master (
    output draw,
    output code,
    output attr,
    output xpos,
    output ysub,
    input  busy
  );

  modport slave (
    input  draw,
    input  code,
    input  attr,
    input  xpos,
    input  ysub,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/jtkiwi_scan.sv
`default_nettype none
// ============================================================================
// Module   : jtkiwi_scan
// Purpose  : Tilemap line scanner for a 32x32 map of 16x16 tiles on a
//            512-pixel line. For each of the 32 columns it fetches the
//            column vertical scroll, the tile code and the tile attribute,
//            then hands one tile to the drawer when the drawer is free.
// Ports    : clk          - clock, rising edge
//            rst          - synchronous active-high reset
//            hs_i         - line-start strobe (restarts a line in progress)
//            vrender_i    - line to render, latched on hs_i
//            hscr_i       - global horizontal scroll, sampled at draw issue
//            scr_addr_o   - column-scroll RAM address (column index)
//            scr_data_i   - column vertical scroll, 1 clock read latency
//            vram_addr_o  - tilemap address {sel,row,col}, sel=1 -> attr
//            vram_data_i  - tilemap word, 1 clock read latency
//            done_o       - one-clock pulse after the last tile of a line
//            drw          - drawer bus (master side)
// Revision : 1.0 - initial release
// ============================================================================
module jtkiwi_scan (
  input  logic                clk,
  input  logic                rst,
  input  logic                hs_i,
  input  logic [8:0]          vrender_i,
  input  logic [8:0]          hscr_i,
  output logic [4:0]          scr_addr_o,
  input  logic [7:0]          scr_data_i,
  output logic [10:0]         vram_addr_o,
  input  logic [15:0]         vram_data_i,
  output logic                done_o,
  jtkiwi_scan_if.master       drw
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SCR   = 3'd1,
    S_ROW   = 3'd2,
    S_CODE  = 3'd3,
    S_ATTR  = 3'd4,
    S_ISSUE = 3'd5,
    S_DRAW  = 3'd6,
    S_HOLD  = 3'd7
  } state_t;

  localparam logic [4:0] C_LAST_COL = 5'd31;

  state_t      state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic [8:0]  vl_q, vl_d;
  // Staging registers: filled during the fetch and copied to the drawer
  // outputs only on a draw edge, so a fetch can overlap the current draw.
  logic [4:0]  row_q, row_d;
  logic [3:0]  ysub_s_q, ysub_s_d;
  logic [15:0] code_s_q, code_s_d;
  logic [15:0] attr_s_q, attr_s_d;
  // Drawer-facing registers
  logic        draw_q, draw_d;
  logic [15:0] code_q, code_d;
  logic [15:0] attr_q, attr_d;
  logic [8:0]  xpos_q, xpos_d;
  logic [3:0]  ysub_q, ysub_d;
  logic        done_q, done_d;

  logic [8:0]  yeff_w;

  // Effective line for this column; 9-bit sum wraps modulo 512.
  assign yeff_w = vl_q + {1'b0, scr_data_i};

  // Addresses follow the state: col is set on entry to SCR, row on the ROW
  // edge, so both are stable through the cycle the RAM samples them.
  assign scr_addr_o  = col_q;
  assign vram_addr_o = {(state_q == S_ATTR), row_q, col_q};

  assign done_o   = done_q;
  assign drw.draw = draw_q;
  assign drw.code = code_q;
  assign drw.attr = attr_q;
  assign drw.xpos = xpos_q;
  assign drw.ysub = ysub_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      col_q    <= '0;
      vl_q     <= '0;
      row_q    <= '0;
      ysub_s_q <= '0;
      code_s_q <= '0;
      attr_s_q <= '0;
      draw_q   <= 1'b0;
      code_q   <= '0;
      attr_q   <= '0;
      xpos_q   <= '0;
      ysub_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      vl_q     <= vl_d;
      row_q    <= row_d;
      ysub_s_q <= ysub_s_d;
      code_s_q <= code_s_d;
      attr_s_q <= attr_s_d;
      draw_q   <= draw_d;
      code_q   <= code_d;
      attr_q   <= attr_d;
      xpos_q   <= xpos_d;
      ysub_q   <= ysub_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    vl_d     = vl_q;
    row_d    = row_q;
    ysub_s_d = ysub_s_q;
    code_s_d = code_s_q;
    attr_s_d = attr_s_q;
    draw_d   = 1'b0;
    code_d   = code_q;
    attr_d   = attr_q;
    xpos_d   = xpos_q;
    ysub_d   = ysub_q;
    done_d   = 1'b0;

    if (hs_i) begin
      // Line start; in any busy state this abandons the current line
      // without a done pulse. Tiles already issued are left untouched.
      vl_d    = vrender_i;
      col_d   = '0;
      state_d = S_SCR;
    end else begin
      case (state_q)
        S_IDLE:  state_d = S_IDLE;
        S_SCR:   state_d = S_ROW;
        S_ROW: begin
          row_d    = yeff_w[8:4];
          ysub_s_d = yeff_w[3:0];
          state_d  = S_CODE;
        end
        S_CODE:  state_d = S_ATTR;
        S_ATTR: begin
          code_s_d = vram_data_i;
          state_d  = S_ISSUE;
        end
        S_ISSUE: begin
          attr_s_d = vram_data_i;
          state_d  = S_DRAW;
        end
        S_DRAW: begin
          if (!drw.busy) begin
            draw_d  = 1'b1;
            code_d  = code_s_q;
            attr_d  = attr_s_q;
            ysub_d  = ysub_s_q;
            xpos_d  = {col_q, 4'd0} + hscr_i;
            state_d = S_HOLD;
          end
        end
        // One clock for busy to rise, so DRAW never sees a stale busy=0.
        S_HOLD: begin
          if (col_q == C_LAST_COL) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            col_d   = col_q + 5'd1;
            state_d = S_SCR;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/jtkiwi_scan.md
JTKIWI_SCAN -- requirements
Module: jtkiwi_scan

Interface
REQ-001 Parameters: none; geometry fixed at a 32x32 map of 16x16 tiles and a 512-px line.
REQ-002 clk  in  1  Single clock; all state updates on the rising edge.
REQ-003 rst  in  1  Reset, synchronous and active-high.
REQ-004 hs  in  1  Line-start strobe, sampled each clock.
REQ-005 vrender  in  9  Line to render, latched when hs is accepted.
REQ-006 hscr  in  9  Global horizontal scroll, sampled on each draw issue.
REQ-007 scr_addr  out  5  Column-scroll RAM address (column index).
REQ-008 scr_data  in  8  Column vertical scroll; valid 1 clock after scr_addr.
REQ-009 vram_addr  out  11  Tilemap address {sel,row[4:0],col[4:0]}; sel=0 selects code, sel=1 selects attr.
REQ-010 vram_data  in  16  Tilemap word; valid 1 clock after vram_addr.
REQ-011 draw  out  1  One-clock tile-draw request to the tile drawer.
REQ-012 code  out  16  Tile code for the drawer.
REQ-013 attr  out  16  Tile attribute for the drawer.
REQ-014 xpos  out  9  Tile start pixel in the line buffer.
REQ-015 ysub  out  4  Row within the tile.
REQ-016 busy  in  1  Drawer busy; rises the clock after draw and stays high while drawing.
REQ-017 done  out  1  One-clock pulse after the final tile of a line has been issued.

Function
REQ-018 States SHALL be IDLE, SCR, ROW, CODE, ATTR, ISSUE, DRAW, HOLD.
REQ-019 IDLE: when hs=1, latch vrender into vl, set col=0, and go to SCR.
REQ-020 SCR: drive scr_addr=col; go to ROW.
REQ-021 ROW: compute yeff=(vl+{1'b0,scr_data}) mod 512; stage row=yeff[8:4] and ysub_s=yeff[3:0]; go to CODE.
REQ-022 CODE: drive vram_addr={0,row,col}; go to ATTR.
REQ-023 ATTR: stage code_s=vram_data; drive vram_addr={1,row,col}; go to ISSUE.
REQ-024 ISSUE: stage attr_s=vram_data; go to DRAW.
REQ-025 DRAW: while busy=1, stay in DRAW with all staging registers held.
REQ-026 DRAW with busy=0: on the same edge, register draw=1, copy the staging registers to code/attr/ysub, set xpos=({col,4'd0}+hscr) mod 512, and go to HOLD.
REQ-027 HOLD: lasts exactly one clock, covering the drawer's busy-rise latency.
REQ-028 HOLD exit: if col=31, pulse done and go to IDLE; otherwise col=col+1 and go to SCR, so the next fetch overlaps the current draw.
REQ-029 code, attr, xpos and ysub SHALL change only on a draw edge and hold stable until the next draw edge, because the drawer reads them throughout busy.
REQ-030 draw SHALL be high for exactly one clock per issue and is never issued while busy=1.
REQ-031 Latency: with busy=0 and hs accepted at edge E0, draw is high in the cycle after edge E6.
REQ-032 Steady-state column period SHALL be max(7 clocks, drawer busy time + 2).
REQ-033 hs=1 in any non-IDLE state SHALL abort the line: latch the new vrender, set col=0, go to SCR, and suppress done.
REQ-034 hs=1 on a HOLD edge with col=31 SHALL take the restart path; done is not pulsed.
REQ-035 A draw already issued is not recalled on abort; the outputs keep their values until the next draw.
REQ-036 xpos and yeff SHALL wrap modulo 512; no saturation.
REQ-037 Exactly 32 draws SHALL be issued per uninterrupted line, with col values 0..31 in order.

Reset
REQ-038 On rst=1 at a clock edge: state=IDLE, col=0, draw=0, done=0, code=0, attr=0, xpos=0, ysub=0, scr_addr=0, vram_addr=0, all staging registers 0.
REQ-039 Reset SHALL take priority over hs; rst asserted mid-line abandons the line with no done pulse.

Verification
REQ-040 Scenario: busy tied 0, vl=0x010, scr_data=0, hscr=0 → 32 draws, xpos=0,16,…,496, ysub=0, vram_addr rows=1, one done pulse.
REQ-041 Scenario: scr_data=0xF8, vrender=0x110 → yeff=0x008 (wrap), row=0, ysub=8; hscr=0x1F8 at col 1 → xpos=0x008.
REQ-042 Scenario: drawer model holds busy 16 clocks after each draw → draws spaced 18 clocks; code/attr/xpos/ysub constant while busy=1.
REQ-043 Scenario: second hs at col 10 → col restarts at 0 with the new vrender, no done for the first line, 32 further draws.
REQ-044 Scenario: rst during DRAW with busy=1 → all outputs 0 next clock, IDLE; no draw until the next hs.
REQ-045 Scenario: busy stuck 1 → the block stays in DRAW indefinitely with no draw, and completes normally once busy falls.
